// File: rtl/ehgu_clk_pkg.sv
// ehgu_clk_pkg: shared types and helpers for the N-phase non-overlapping clock generator.
//   nphase_state_t : FSM state encoding (IDLE, ACTIVE, GAP)
//   idx_w()        : width of the phase index for a given phase count
package ehgu_clk_pkg;

   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} nphase_state_t;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ehgu_clk_nphase.sv
// ehgu_clk_nphase: counter-based generator of NPH mutually non-overlapping phase clocks.
//   clkin       : source clock, all logic on posedge
//   rst         : asynchronous active-high reset
//   en          : run request, acted on only when idle or at the end of a frame
//   high_cyc    : phase high time in clkin cycles (0 behaves as 1)
//   gap_cyc     : dead time between consecutive phases (0 allowed)
//   clkp        : registered one-hot-or-zero phase clocks
//   phase_idx   : index of the current or last active phase
//   frame_start : one-cycle pulse coincident with clkp[0] rising
//   busy        : high whenever the FSM is not idle
module ehgu_clk_nphase
   import ehgu_clk_pkg::*;
#(
   parameter int NPH = 2,
   parameter int CW  = 8
) (
   input  logic                   clkin,
   input  logic                   rst,
   input  logic                   en,
   input  logic [CW-1:0]          high_cyc,
   input  logic [CW-1:0]          gap_cyc,
   output logic [NPH-1:0]         clkp,
   output logic [idx_w(NPH)-1:0]  phase_idx,
   output logic                   frame_start,
   output logic                   busy
);

   localparam int IW = idx_w(NPH);

   nphase_state_t state;
   logic [CW-1:0] cnt, high_l, gap_l;
   logic          act_end, gap_end, adv, wrap, start;
   logic [IW-1:0] nidx;

   // Comparisons use latched value minus one, so high_cyc = 2^CW-1 never overflows cnt.
   always_comb begin
      act_end = (state == ACTIVE) && (cnt == high_l - 1'b1);
      gap_end = (state == GAP) && (cnt == gap_l - 1'b1);
      adv     = (act_end && (gap_l == '0)) || gap_end;
      wrap    = (phase_idx == IW'(NPH - 1));
      start   = ((state == IDLE) && en) || (adv && wrap && en);
      nidx    = phase_idx + 1'b1;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         high_l      <= '0;
         gap_l       <= '0;
         clkp        <= '0;
         phase_idx   <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= start;
         if (start) begin
            state     <= ACTIVE;
            high_l    <= (high_cyc == '0) ? CW'(1) : high_cyc;
            gap_l     <= gap_cyc;
            clkp      <= NPH'(1);
            phase_idx <= '0;
            cnt       <= '0;
         end else if (adv && wrap) begin
            state <= IDLE;
            clkp  <= '0;
            cnt   <= '0;
         end else if (adv) begin
            // Falling and rising phases switch on the same edge; both are registered.
            state     <= ACTIVE;
            phase_idx <= nidx;
            clkp      <= NPH'(1) << nidx;
            cnt       <= '0;
         end else if (act_end) begin
            state <= GAP;
            clkp  <= '0;
            cnt   <= '0;
         end else if (state != IDLE) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ehgu_clk_nphase.sv
// tb_ehgu_clk_nphase: randomized and directed bench for ehgu_clk_nphase with NPH = 2, 3, 4.
module tb_ehgu_clk_nphase;

   logic       clkin = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] high_cyc = '0;
   logic [7:0] gap_cyc = '0;

   logic [1:0] p2;
   logic [2:0] p3;
   logic [3:0] p4;
   logic       i2;
   logic [1:0] i3, i4;
   logic [2:0] fs, bz;

   int checks = 0;
   int failures = 0;

   int nph [3] = '{2, 3, 4};
   int run [3];
   int pos [3];
   int hl [3];
   int gl [3];
   int lastp [3];

   always #5 clkin = ~clkin;

   ehgu_clk_nphase #(.NPH(2), .CW(8)) u2 (.clkin(clkin), .rst(rst), .en(en), .high_cyc(high_cyc),
      .gap_cyc(gap_cyc), .clkp(p2), .phase_idx(i2), .frame_start(fs[0]), .busy(bz[0]));
   ehgu_clk_nphase #(.NPH(3), .CW(8)) u3 (.clkin(clkin), .rst(rst), .en(en), .high_cyc(high_cyc),
      .gap_cyc(gap_cyc), .clkp(p3), .phase_idx(i3), .frame_start(fs[1]), .busy(bz[1]));
   ehgu_clk_nphase #(.NPH(4), .CW(8)) u4 (.clkin(clkin), .rst(rst), .en(en), .high_cyc(high_cyc),
      .gap_cyc(gap_cyc), .clkp(p4), .phase_idx(i4), .frame_start(fs[2]), .busy(bz[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic void mreset();
      for (int k = 0; k < 3; k++) begin
         run[k] = 0; pos[k] = 0; hl[k] = 0; gl[k] = 0; lastp[k] = 0;
      end
   endfunction

   // Frame-schedule model: a frame is NPH slots of (high + gap) cycles, high first.
   function automatic void mstep();
      for (int k = 0; k < 3; k++) begin
         if (run[k] == 0) begin
            if (en) begin
               run[k] = 1; pos[k] = 0;
               hl[k] = (high_cyc == 0) ? 1 : int'(high_cyc);
               gl[k] = int'(gap_cyc);
            end
         end else begin
            pos[k]++;
            if (pos[k] == nph[k] * (hl[k] + gl[k])) begin
               if (en) begin
                  pos[k] = 0;
                  hl[k] = (high_cyc == 0) ? 1 : int'(high_cyc);
                  gl[k] = int'(gap_cyc);
               end else begin
                  run[k] = 0;
               end
            end
         end
         if (run[k] != 0) lastp[k] = pos[k] / (hl[k] + gl[k]);
      end
   endfunction

   task automatic check_all();
      logic [31:0] ac, ai, ec;
      int slot, off;
      for (int k = 0; k < 3; k++) begin
         ac = (k == 0) ? 32'(p2) : (k == 1) ? 32'(p3) : 32'(p4);
         ai = (k == 0) ? 32'(i2) : (k == 1) ? 32'(i3) : 32'(i4);
         ec = 0;
         if (run[k] != 0) begin
            slot = pos[k] / (hl[k] + gl[k]);
            off = pos[k] % (hl[k] + gl[k]);
            if (off < hl[k]) ec = 32'(1) << slot;
         end
         chk($sformatf("clkp[nph=%0d]", nph[k]), ac, ec);
         chk($sformatf("phase_idx[nph=%0d]", nph[k]), ai, 32'(lastp[k]));
         chk($sformatf("frame_start[nph=%0d]", nph[k]), 32'(fs[k]), 32'(run[k] != 0 && pos[k] == 0));
         chk($sformatf("busy[nph=%0d]", nph[k]), 32'(bz[k]), 32'(run[k] != 0));
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clkin);
         mstep();
         @(negedge clkin);
         check_all();
      end
   endtask

   initial begin
      int waited;
      mreset();
      repeat (2) @(negedge clkin);
      check_all();
      rst = 1'b0;
      en = 1'b1; high_cyc = 8'd3; gap_cyc = 8'd1;
      cyc(90);
      high_cyc = 8'd2; gap_cyc = 8'd0;
      cyc(60);
      high_cyc = 8'd0; gap_cyc = 8'd2;
      cyc(60);
      high_cyc = 8'd2; gap_cyc = 8'd1;
      cyc(7);
      en = 1'b0;
      cyc(40);
      en = 1'b1;
      cyc(20);
      high_cyc = 8'd5;
      cyc(60);
      high_cyc = 8'd2; gap_cyc = 8'd1;
      waited = 0;
      while (p2[1] !== 1'b1 && waited < 50) begin
         cyc(1);
         waited++;
      end
      chk("rst_wait_clkp1", 32'(p2[1]), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_clkp", {p4, p3, p2}, 32'd0);
      chk("async_rst_busy", 32'(bz), 32'd0);
      chk("async_rst_fs", 32'(fs), 32'd0);
      mreset();
      @(negedge clkin);
      rst = 1'b0;
      cyc(30);
      high_cyc = 8'd255; gap_cyc = 8'd1;
      cyc(2);
      high_cyc = 8'd1;
      cyc(1100);
      for (int n = 0; n < 2500; n++) begin
         if ($urandom_range(7) == 0) begin
            en = ($urandom_range(9) < 8);
            high_cyc = ($urandom_range(15) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(4));
            gap_cyc = 8'($urandom_range(3));
         end
         cyc(1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ehgu_clk_nphase.md
Name: ehgu_clk_nphase

Overview:
Parametrised successor to the two-phase non-overlapping clock generator. Derives NPH mutually non-overlapping phase clocks from clkin using counters, not analog delays. Phase high time and inter-phase dead time are runtime-programmable in clkin cycles. Feeds multi-phase latch pipelines and switched-cap style test structures in the clocking examples.

Parameters:
NPH, 2, number of output phases (2..16)
CW, 8, width of high/gap cycle-count fields

Ports:
clkin  input  1  source clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
en  input  1  run request; sampled every cycle
high_cyc  input  CW  phase high time in clkin cycles (0 treated as 1)
gap_cyc  input  CW  dead time between consecutive phases in clkin cycles (0 allowed)
clkp  output  NPH  phase clocks; bit i = phase i; registered
phase_idx  output  $clog2(NPH)  index of current/last active phase
frame_start  output  1  one-cycle pulse coincident with clkp[0] rising
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync-to-clkin deassert by user): clkp=0, phase_idx=0, frame_start=0, busy=0, state=IDLE, counters=0. Reset mid-frame drops all phases immediately, without completing the frame.
- Invariant: clkp is onehot0 on every cycle, for any config, including gap_cyc=0.
- FSM states: IDLE, ACTIVE, GAP.
- IDLE: when en=1 is sampled, latch high_l=max(high_cyc,1) and gap_l=gap_cyc. Next cycle: state=ACTIVE, clkp[0]=1, phase_idx=0, frame_start=1, busy=1. Latency from en sample to clkp[0] is 1 cycle.
- ACTIVE: clkp[phase_idx]=1 for exactly high_l cycles (cnt 0..high_l-1). At the last cycle:
  - If gap_l>0: go to GAP; clkp=0 next cycle.
  - If gap_l=0: advance directly to the next phase. clkp[idx] falls and clkp[idx+1] rises on the same edge. Both are registered, so there is no overlap.
- GAP: clkp=0 for exactly gap_l cycles, then advance to the next phase.
- Advance: idx+1. When idx=NPH-1 the index wraps to 0 (end of frame):
  - If en=1 at that cycle: re-latch high_cyc/gap_cyc, enter ACTIVE with idx=0, frame_start=1.
  - If en=0: enter IDLE; clkp=0, busy=0.
- en is checked only at the end of a frame. Frames always complete; no truncated phases. Config changes mid-frame are ignored until the next frame.
- Frame period = NPH*(high_l+gap_l) cycles. Each phase has the same frequency, clkin/period, and duty high_l/period.
- Counters are CW bits. high_cyc=2^CW-1 is legal; there is no overflow because comparison uses the latched value minus 1.
- en and rst together: rst dominates.

Decomposition:
- Shared package ehgu_clk_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACTIVE, GAP} nphase_state_t
  - localparam helper function for the idx width: max(1,$clog2(NPH))
- No sub-module. The single FSM plus one down/up counter fits in one module.

Test Plan:
- NPH=2, high_cyc=3, gap_cyc=1, en held high, 10 frames. Required response:
  - each clkp bit has period 8 cycles and duty 37.5%
  - clkp[1] rises 4 cycles after clkp[0]
  - onehot0 assertion never fires
  - the freq meter reads fin/8 on both phases
- NPH=4, high_cyc=2, gap_cyc=0. Required response:
  - phases rise back-to-back every 2 cycles
  - each clkp bit has period 8
  - clkp==0 never occurs while busy
  - no overlap
- high_cyc=0, gap_cyc=2, NPH=3. Required response: behaves as high=1, i.e. 1-cycle pulses with period 9.
- Drop en mid-frame (NPH=4, high=2, gap=1). Required response:
  - the frame completes through clkp[3] and its gap
  - then busy=0, clkp=0
  - the next en=1 sample gives clkp[0] high exactly 1 cycle later, with frame_start=1
- Change high_cyc from 2 to 5 in the middle of a frame. Required response: the current frame keeps high=2; the next frame uses 5, starting at the cycle frame_start pulses.
- Assert rst while clkp[1] is high. Required response:
  - clkp, busy and frame_start go to 0 immediately, without waiting for a clkin edge
  - after release with en=1, the sequence restarts at phase 0
